md_unit: RTL and testbench

- Multiply/divide unit in the Execute stage of the 5-stage pipeline. It owns the HI/LO registers.
- It runs MULT/MULTU/DIV/DIVU as multi-cycle operations with a busy countdown, and executes MTHI/MTLO/MFHI/MFLO.
- It produces the MD-hazard stall request, which is OR'd with the stall controller's data-hazard stall to freeze PC and the D register and bubble E.

---
 rtl/md_unit_pkg.sv | 40 ++++
 rtl/md_unit_if.sv | 25 ++
 rtl/md_arith.sv | 62 ++++++
 rtl/md_unit.sv | 109 ++++++++++
 tb/tb_md_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared MD-unit constants: op codes, FSM states, result payload and op-class helpers.
package md_unit_pkg;

  localparam int unsigned MdOpW = 4;
  localparam int unsigned DataW = 32;

  // MD operation codes carried by the E-stage instruction
  typedef enum logic [MdOpW-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } mdOp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdState_t;

  // 64-bit arithmetic result split into HI/LO halves
  typedef struct packed {
    logic [DataW-1:0] hi;
    logic [DataW-1:0] lo;
  } mdResult_t;

  // True for ops that occupy the unit for a busy countdown
  function automatic logic isMultiCycle(input logic [MdOpW-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isDivide(input logic [MdOpW-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// MD-unit pipeline interface.
//   start, md_op, rs_val, rt_val, md_use_D : pipeline -> unit
//   busy, md_stall, md_rdata               : unit -> pipeline
interface md_unit_if;
  import md_unit_pkg::*;

  logic             start;
  logic [MdOpW-1:0] md_op;
  logic [DataW-1:0] rs_val;
  logic [DataW-1:0] rt_val;
  logic             md_use_D;
  logic             busy;
  logic             md_stall;
  logic [DataW-1:0] md_rdata;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_D,
    input  busy, md_stall, md_rdata
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_D,
    output busy, md_stall, md_rdata
  );
endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide result generator.
//   op      : MD op code (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b    : rs / rt operands
//   result  : {hi, lo}; zero for non-arithmetic ops
//   divZero : divide op with b == 0 (result must not be committed)
module md_arith
  import md_unit_pkg::*;
(
  input  logic [MdOpW-1:0] op,
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  output mdResult_t        result,
  output logic             divZero
);

  logic signed [2*DataW-1:0] sA, sB, sProd;
  logic [2*DataW-1:0]        uProd;
  logic [DataW-1:0]          bSafe, aMag, bMag, bMagSafe;
  logic [DataW-1:0]          magQ, magR, sQ, sR, uQ, uR;

  assign sA    = {{DataW{a[DataW-1]}}, a};
  assign sB    = {{DataW{b[DataW-1]}}, b};
  assign sProd = sA * sB;
  assign uProd = {{DataW{1'b0}}, a} * {{DataW{1'b0}}, b};

  // Divisor forced nonzero so the dividers never see zero; result is discarded then anyway
  assign bSafe = (b == '0) ? DataW'(1) : b;

  // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow (|INT_MIN| fits unsigned)
  assign aMag     = a[DataW-1] ? (~a + DataW'(1)) : a;
  assign bMag     = b[DataW-1] ? (~b + DataW'(1)) : b;
  assign bMagSafe = (bMag == '0) ? DataW'(1) : bMag;
  assign magQ     = aMag / bMagSafe;
  assign magR     = aMag % bMagSafe;
  assign sQ       = (a[DataW-1] ^ b[DataW-1]) ? (~magQ + DataW'(1)) : magQ;
  assign sR       = a[DataW-1] ? (~magR + DataW'(1)) : magR;

  assign uQ = a / bSafe;
  assign uR = a % bSafe;

  // Result select
  always_comb begin
    result  = '0;
    divZero = 1'b0;
    case (op)
      MD_MULT:  result = mdResult_t'(sProd);
      MD_MULTU: result = mdResult_t'(uProd);
      MD_DIV: begin
        result.hi = sR;
        result.lo = sQ;
        divZero   = (b == '0);
      end
      MD_DIVU: begin
        result.hi = uR;
        result.lo = uQ;
        divZero   = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
//   clk, rst_n : clock (rising edge), async active-low reset
//   mdIf       : slave side of md_unit_if (op request in, busy/stall/read data out)
// Multi-cycle ops latch their result at start and commit it to HI/LO when the
// busy countdown expires; MTHI/MTLO write immediately; MFHI/MFLO read combinationally.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  md_unit_if.slave   mdIf
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdState_t         state, stateNext;
  logic [CntW-1:0]  cnt, cntNext;
  mdResult_t        pend, pendNext;
  logic             pendWr, pendWrNext;
  logic [DataW-1:0] hi, hiNext, lo, loNext;
  mdResult_t        arithRes;
  logic             divZero;
  logic [DataW-1:0] rdata;

  md_arith uArith (
    .op      (mdIf.md_op),
    .a       (mdIf.rs_val),
    .b       (mdIf.rt_val),
    .result  (arithRes),
    .divZero (divZero)
  );

  // State, countdown, pending result and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pend   <= '0;
      pendWr <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      pend   <= pendNext;
      pendWr <= pendWrNext;
      hi     <= hiNext;
      lo     <= loNext;
    end
  end

  // Next-state: accept ops only when idle; starts while busy are dropped
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    pendNext   = pend;
    pendWrNext = pendWr;
    hiNext     = hi;
    loNext     = lo;
    case (state)
      ST_IDLE: begin
        if (mdIf.start) begin
          if (isMultiCycle(mdIf.md_op)) begin
            pendNext   = arithRes;
            pendWrNext = !divZero;
            cntNext    = isDivide(mdIf.md_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            stateNext  = ST_BUSY;
          end else if (mdIf.md_op == MD_MTHI) begin
            hiNext = mdIf.rs_val;
          end else if (mdIf.md_op == MD_MTLO) begin
            loNext = mdIf.rs_val;
          end
        end
      end
      ST_BUSY: begin
        cntNext = cnt - CntW'(1);
        if (cnt == CntW'(1)) begin
          stateNext = ST_IDLE;
          if (pendWr) begin
            hiNext = pend.hi;
            loNext = pend.lo;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // MFHI/MFLO read port
  always_comb begin
    rdata = '0;
    if (mdIf.md_op == MD_MFHI) begin
      rdata = hi;
    end else if (mdIf.md_op == MD_MFLO) begin
      rdata = lo;
    end
  end

  assign mdIf.busy     = (state == ST_BUSY);
  assign mdIf.md_rdata = rdata;
  // Hold an MD instruction in D through the start cycle and every busy cycle
  assign mdIf.md_stall = mdIf.md_use_D &
                         ((state == ST_BUSY) | (mdIf.start & isMultiCycle(mdIf.md_op)));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against a
// cycle-schedule reference model using plain 64-bit arithmetic.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_unit_if mdIf ();

  md_unit #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdIf  (mdIf)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: visible HI/LO plus a schedule of the in-flight op
  logic [31:0] mHi, mLo, pHi, pLo;
  bit          pWr;
  int          cyc, startCyc, busyEnd;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit refIsMulti(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4};
  endfunction

  // Full 64-bit results computed with host arithmetic
  task automatic refArith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    pWr = 1'b1;
    case (op)
      MD_MULT:  begin sp = sa * sb; pHi = sp[63:32]; pLo = sp[31:0]; end
      MD_MULTU: begin up = ua * ub; pHi = up[63:32]; pLo = up[31:0]; end
      MD_DIV: begin
        if (b == 0) pWr = 1'b0;
        else begin q = sa / sb; r = sa % sb; pLo = q[31:0]; pHi = r[31:0]; end
      end
      MD_DIVU: begin
        if (b == 0) pWr = 1'b0;
        else begin pLo = a / b; pHi = a % b; end
      end
      default: pWr = 1'b0;
    endcase
  endtask

  // One clock cycle: drive, check at negedge, then advance the model over the edge
  task automatic runCycle(input logic st, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic useD, output logic [31:0] rdOut);
    bit          expBusy, expStall;
    logic [31:0] expRd;
    mdIf.start    = st;
    mdIf.md_op    = op;
    mdIf.rs_val   = rs;
    mdIf.rt_val   = rt;
    mdIf.md_use_D = useD;
    @(negedge clk);
    expBusy  = (cyc > startCyc) && (cyc <= busyEnd);
    expStall = useD && (expBusy || (st && refIsMulti(op)));
    expRd    = (op == 4'd7) ? mHi : (op == 4'd8) ? mLo : 32'd0;
    checkVal("busy", 32'(mdIf.busy), 32'(expBusy));
    checkVal("md_stall", 32'(mdIf.md_stall), 32'(expStall));
    checkVal("md_rdata", mdIf.md_rdata, expRd);
    rdOut = mdIf.md_rdata;
    @(posedge clk);
    if (expBusy && cyc == busyEnd && pWr) begin
      mHi = pHi;
      mLo = pLo;
    end
    if (st && !expBusy) begin
      if (refIsMulti(op)) begin
        refArith(op, rs, rt);
        startCyc = cyc;
        busyEnd  = cyc + ((op == 4'd3 || op == 4'd4) ? DivN : MultN);
      end else if (op == 4'd5) begin
        mHi = rs;
      end else if (op == 4'd6) begin
        mLo = rs;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic useD);
    logic [31:0] rd;
    repeat (n) runCycle(1'b0, MD_NONE, 32'd0, 32'd0, useD, rd);
  endtask

  task automatic readHiLo(output logic [31:0] h, output logic [31:0] l);
    runCycle(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b1, h);
    runCycle(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b1, l);
  endtask

  // Async reset in mid-cycle; outputs must clear without waiting for a clock edge
  task automatic resetPulse();
    mdIf.start    = 1'b0;
    mdIf.md_op    = MD_MFHI;
    mdIf.md_use_D = 1'b1;
    rst_n = 1'b0;
    #1;
    checkVal("rst_busy", 32'(mdIf.busy), 32'd0);
    checkVal("rst_stall", 32'(mdIf.md_stall), 32'd0);
    checkVal("rst_hi", mdIf.md_rdata, 32'd0);
    mdIf.md_op = MD_MFLO;
    #1;
    checkVal("rst_lo", mdIf.md_rdata, 32'd0);
    mHi = '0; mLo = '0; pWr = 1'b0; busyEnd = -1;
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [31:0] rd, h, l;
  logic [3:0]  rop;
  logic        rst;

  initial begin
    mHi = '0; mLo = '0; pHi = '0; pLo = '0; pWr = 1'b0;
    cyc = 0; startCyc = -1; busyEnd = -1;
    mdIf.start = 1'b0; mdIf.md_op = MD_NONE; mdIf.rs_val = '0; mdIf.rt_val = '0; mdIf.md_use_D = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_busy", 32'(mdIf.busy), 32'd0);
    mdIf.md_op = MD_MFHI;
    #1;
    checkVal("reset_hi", mdIf.md_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MULT -2 * 3
    runCycle(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, rd);
    idle(MultN, 1'b1);
    readHiLo(h, l);
    checkVal("mult_hi", h, 32'hFFFF_FFFF);
    checkVal("mult_lo", l, 32'hFFFF_FFFA);

    // DIVU 100 / 7
    runCycle(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b1, rd);
    idle(DivN, 1'b1);
    readHiLo(h, l);
    checkVal("divu_hi", h, 32'd2);
    checkVal("divu_lo", l, 32'd14);

    // DIV -7 / 2
    runCycle(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, rd);
    idle(DivN, 1'b0);
    readHiLo(h, l);
    checkVal("div_hi", h, 32'hFFFF_FFFF);
    checkVal("div_lo", l, 32'hFFFF_FFFD);

    // Divide by zero leaves HI/LO untouched
    runCycle(1'b1, MD_MTHI, 32'h11, 32'd0, 1'b1, rd);
    runCycle(1'b1, MD_MTLO, 32'h22, 32'd0, 1'b1, rd);
    runCycle(1'b1, MD_DIV, 32'd55, 32'd0, 1'b1, rd);
    idle(DivN, 1'b1);
    readHiLo(h, l);
    checkVal("dz_hi", h, 32'h11);
    checkVal("dz_lo", l, 32'h22);

    // INT_MIN / -1
    runCycle(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, rd);
    idle(DivN, 1'b1);
    readHiLo(h, l);
    checkVal("ovf_hi", h, 32'd0);
    checkVal("ovf_lo", l, 32'h8000_0000);

    // MTLO then MFLO next cycle
    runCycle(1'b1, MD_MTLO, 32'hABCD, 32'd0, 1'b1, rd);
    runCycle(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b1, rd);
    checkVal("mtlo_rd", rd, 32'hABCD);

    // Reset in the middle of a MULT abandons it
    runCycle(1'b1, MD_MTHI, 32'h5, 32'd0, 1'b1, rd);
    runCycle(1'b1, MD_MULT, 32'd7, 32'd9, 1'b1, rd);
    idle(2, 1'b1);
    resetPulse();
    idle(MultN, 1'b1);
    readHiLo(h, l);
    checkVal("rstmul_hi", h, 32'd0);
    checkVal("rstmul_lo", l, 32'd0);

    // Illegal start while busy is ignored; no stall with md_use_D low
    runCycle(1'b1, MD_MULTU, 32'd1000, 32'd1000, 1'b0, rd);
    runCycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, rd);
    runCycle(1'b1, MD_DIVU, 32'd9, 32'd3, 1'b0, rd);
    runCycle(1'b1, MD_MTHI, 32'hDEAD, 32'd0, 1'b0, rd);
    idle(MultN - 3, 1'b0);
    readHiLo(h, l);
    checkVal("ign_hi", h, 32'd0);
    checkVal("ign_lo", l, 32'd1000000);
    checkVal("ign_busy", 32'(mdIf.busy), 32'd0);

    // Randomized ops, including unknown codes, starts while busy and resets
    for (int i = 0; i < 1500; i++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) rop = 4'($urandom_range(0, 8));
      rst = ($urandom_range(0, 199) == 0);
      if (rst) resetPulse();
      runCycle(($urandom_range(0, 3) != 0), rop, pickOperand(), pickOperand(),
               1'($urandom_range(0, 1)), rd);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
